// File: rtl/rho_rotate_pkg.sv
// rho_rotate_pkg
//   Shared definitions for the Keccak rho stage:
//   - COUNT       : lane length, equal to the number of slices per state
//   - RHO_OFFSETS : rho rotation offset per lane, indexed by i = x + 5*y
//   - lane_index  : maps lane coordinates (x,y) to the flat lane index
//   - ST_IDLE/ST_LOAD/ST_OUT : controller state encoding
package rho_rotate_pkg;

  localparam int COUNT = 64;
  localparam int LANES = 25;

  localparam int unsigned RHO_OFFSETS [LANES] = '{
    0,  1,  62, 28, 27,
    36, 44, 6,  55, 20,
    3,  10, 43, 25, 39,
    41, 45, 15, 21, 8,
    18, 2,  61, 56, 14
  };

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;

  function automatic int lane_index(input int x, input int y);
    return x + 5 * y;
  endfunction

endpackage

// File: rtl/rho_rotate_controller.sv
// rho_rotate_controller
//   IDLE/LOAD/OUT sequencer for one state per run.
//   Ports:
//     clk, rst  : clock and synchronous active-high reset
//     start     : begin a run, only honoured in IDLE
//     co        : slice counter at its last slice
//     ready     : high in IDLE
//     put_input : high in LOAD
//     out_ready : high in OUT
//     cnt_en    : advance the slice counter
//     cnt_clr   : clear the slice counter
module rho_rotate_controller
  import rho_rotate_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic co,
  output logic ready,
  output logic put_input,
  output logic out_ready,
  output logic cnt_en,
  output logic cnt_clr
);

  logic [1:0] state;
  logic [1:0] next_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (start) next_state = ST_LOAD;
      ST_LOAD: if (co)    next_state = ST_OUT;
      ST_OUT:  if (co)    next_state = ST_IDLE;
      default:            next_state = ST_IDLE;
    endcase
  end

  // The counter idles at zero and is cleared on the last slice of each
  // phase, so every state is entered with the count at zero.
  assign cnt_en  = (state == ST_LOAD) || (state == ST_OUT);
  assign cnt_clr = (state == ST_IDLE) || co;

  assign ready     = (state == ST_IDLE);
  assign put_input = (state == ST_LOAD);
  assign out_ready = (state == ST_OUT);

endmodule

// File: rtl/rho_rotate_datapath.sv
// rho_rotate_datapath
//   25 lane registers of 64 bits, rho rotation wiring and output mux.
//   Ports:
//     clk, rst  : clock and synchronous active-high reset (clears lanes)
//     load      : write slice_in into bit z_cnt of every lane
//     out_en    : drive the rotated slice, otherwise zero
//     z_cnt     : current slice index
//     slice_in  : incoming slice, bit i belongs to lane i
//     slice_out : rotated slice z_cnt
module rho_rotate_datapath
  import rho_rotate_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        out_en,
  input  logic [5:0]  z_cnt,
  input  logic [24:0] slice_in,
  output logic [24:0] slice_out
);

  logic [COUNT-1:0] lane [LANES];
  logic [24:0]      rotated;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LANES; i++) begin
        lane[i] <= '0;
      end
    end else if (load) begin
      for (int i = 0; i < LANES; i++) begin
        lane[i][z_cnt] <= slice_in[i];
      end
    end
  end

  // Rotating left by r means output bit z comes from stored bit z - r;
  // 6-bit subtraction supplies the mod-64 wrap for free.
  for (genvar gy = 0; gy < 5; gy++) begin : g_row
    for (genvar gx = 0; gx < 5; gx++) begin : g_col
      localparam int         Idx = lane_index(gx, gy);
      localparam logic [5:0] Rot = 6'(RHO_OFFSETS[Idx]);
      logic [5:0] src;
      assign src          = z_cnt - Rot;
      assign rotated[Idx] = lane[Idx][src];
    end
  end

  assign slice_out = out_en ? rotated : 25'h0;

endmodule

// File: rtl/slice_counter.sv
// slice_counter
//   6-bit slice index counter that wraps 63 -> 0.
//   Ports:
//     clk, rst : clock and synchronous active-high reset
//     en       : advance the count by one
//     clr      : return the count to zero (wins over en)
//     cnt      : current slice index
//     co       : high while cnt is at the last slice
module slice_counter
  import rho_rotate_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  output logic [5:0] cnt,
  output logic       co
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= 6'd0;
    end else if (en) begin
      cnt <= cnt + 6'd1;
    end
  end

  assign co = (cnt == 6'(COUNT - 1));

endmodule

// File: rtl/rho_rotate.sv
// rho_rotate
//   Keccak rho stage: loads 64 slices of 25 bits, rotates every lane by its
//   rho offset and streams the 64 rotated slices out in z order.
//   Ports:
//     clk, rst  : clock and synchronous active-high reset
//     start     : begin a run (sampled in IDLE only)
//     matrixIn  : input slice z during the z-th putInput cycle
//     ready     : high while idle
//     putInput  : high while slices are being accepted
//     outReady  : high while matrixOut carries a valid rotated slice
//     matrixOut : rotated slice z during the z-th outReady cycle, else 0
module rho_rotate
  import rho_rotate_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [24:0] matrixIn,
  output logic        ready,
  output logic        putInput,
  output logic        outReady,
  output logic [24:0] matrixOut
);

  logic [5:0] z_cnt;
  logic       co;
  logic       cnt_en;
  logic       cnt_clr;

  rho_rotate_controller u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .co        (co),
    .ready     (ready),
    .put_input (putInput),
    .out_ready (outReady),
    .cnt_en    (cnt_en),
    .cnt_clr   (cnt_clr)
  );

  slice_counter u_cnt (
    .clk (clk),
    .rst (rst),
    .en  (cnt_en),
    .clr (cnt_clr),
    .cnt (z_cnt),
    .co  (co)
  );

  rho_rotate_datapath u_dp (
    .clk       (clk),
    .rst       (rst),
    .load      (putInput),
    .out_en    (outReady),
    .z_cnt     (z_cnt),
    .slice_in  (matrixIn),
    .slice_out (matrixOut)
  );

endmodule
